// File: rtl/dg_pkg.sv
// Shared display-board definitions used by the button front-end and the
// auto-repeat pulse generator.
package dg_pkg;

  localparam int unsigned CLOCK_PERIOD_NS = 20;

  // Buttons are active-low, so an idle pin and an idle output both read 1.
  localparam logic BUTTON_IDLE = 1'b1;

  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_SIGNED = 2;

  typedef enum logic {
    LEVEL_PRESSED  = 1'b0,
    LEVEL_RELEASED = 1'b1
  } button_level_t;

  // Whole clock cycles that fit in a time interval (truncating).
  function automatic int unsigned ns_to_cycles(input int unsigned ns,
                                               input int unsigned period_ns);
    return ns / period_ns;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: synchroniser chain, stability counter, debounced level and
// one-cycle press/release strobes.
module debounce_channel
  import dg_pkg::*;
#(
  parameter int unsigned MaxCount   = 5,
  parameter int unsigned SyncStages = 2
) (
  input  logic Clock,
  input  logic nReset,
  input  logic iPin,
  output logic oLevel,
  output logic oPressed,
  output logic oReleased
);

  localparam int unsigned CountWidth = $clog2(MaxCount + 1);
  localparam logic [CountWidth-1:0] CountLast = CountWidth'(MaxCount - 1);
  localparam logic [CountWidth-1:0] CountOne  = CountWidth'(1);

  logic [SyncStages-1:0] sync_reg;
  logic [CountWidth-1:0] count_reg;
  button_level_t         stable_reg;
  logic                  pressed_reg;
  logic                  released_reg;
  logic                  sync_bit;

  assign sync_bit = sync_reg[SyncStages-1];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync_reg     <= {SyncStages{BUTTON_IDLE}};
      count_reg    <= '0;
      stable_reg   <= LEVEL_RELEASED;
      pressed_reg  <= 1'b0;
      released_reg <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[SyncStages-2:0], iPin};
      pressed_reg  <= 1'b0;
      released_reg <= 1'b0;
      if (sync_bit == stable_reg) begin
        // Any sample agreeing with the current level restarts the interval.
        count_reg <= '0;
      end else if (count_reg >= CountLast) begin
        stable_reg   <= button_level_t'(sync_bit);
        count_reg    <= '0;
        pressed_reg  <= ~sync_bit;
        released_reg <= sync_bit;
      end else begin
        count_reg <= count_reg + CountOne;
      end
    end
  end

  assign oLevel    = stable_reg;
  assign oPressed  = pressed_reg;
  assign oReleased = released_reg;

endmodule

// File: rtl/button_debouncer.sv
// Debounced, synchronised front-end for the active-low board buttons
// (bit0 Up, bit1 Down, bit2 Signed) feeding the auto-repeat generator.
module button_debouncer
  import dg_pkg::*;
#(
  parameter int unsigned ClockPeriod_ns      = CLOCK_PERIOD_NS,
  parameter int unsigned DebounceInterval_ns = 10_000_000,
  parameter int unsigned Channels            = 3,
  parameter int unsigned SyncStages          = 2
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic [Channels-1:0] iButtons,
  output logic [Channels-1:0] oButtons,
  output logic [Channels-1:0] oPressed,
  output logic [Channels-1:0] oReleased,
  output logic                oAnyPressed
);

  localparam int unsigned MaxCount = ns_to_cycles(DebounceInterval_ns, ClockPeriod_ns);

  generate
    if (MaxCount < 2) begin : g_bad_interval
      $error("button_debouncer: debounce interval must span at least 2 clock cycles");
    end
    if (SyncStages < 2) begin : g_bad_sync
      $error("button_debouncer: at least 2 synchroniser stages are required");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < Channels; gi++) begin : g_channel
      debounce_channel #(
        .MaxCount   (MaxCount),
        .SyncStages (SyncStages)
      ) u_channel (
        .Clock     (Clock),
        .nReset    (nReset),
        .iPin      (iButtons[gi]),
        .oLevel    (oButtons[gi]),
        .oPressed  (oPressed[gi]),
        .oReleased (oReleased[gi])
      );
    end
  endgenerate

  // Derived from registered levels, so it is glitch-free despite being combinational.
  assign oAnyPressed = |(~oButtons);

endmodule
